// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if
// ---------------------
// Bundles the request and response signals of the nibble-serial add/subtract
// sequencer so the requester and the sequencer connect through one port.
//
// Parameter
//   NIBBLES   number of 4-bit slices, operand width W = 4*NIBBLES (1..16)
//
// Signals
//   start     request; only looked at while the sequencer is idle
//   op        0 = A+B, 1 = A-B; taken together with start
//   a, b      W-bit operands; taken together with start
//   busy      an operation is in flight
//   done      one-cycle completion pulse
//   result    W-bit sum/difference, held until the next completion
//   cout      carry out of the MSB (for subtract: 1 = no borrow)
//   overflow  two's-complement overflow
//   zero      result is all zeros
//
// Modports
//   master    requester side: drives start/op/a/b, observes the results
//   slave     sequencer side: observes the request, drives the results
interface serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// ------------------
// Nibble-serial add/subtract sequencer. A W-bit (W = 4*NIBBLES) add or
// subtract is carried out by one 4-bit slice, one nibble per clock, least
// significant nibble first, with the carry registered between nibbles.
// One operation is accepted per start pulse while idle; completion is
// signalled by a one-cycle done pulse together with result, carry/borrow,
// signed overflow and zero flags, which then hold until the next completion.
//
// Parameter
//   NIBBLES   number of 4-bit slices (1..16)
//
// Ports
//   clk       single clock, rising edge
//   reset_n   asynchronous, active-low reset; discards any operation in flight
//   bus       serial_addsub_ctrl_if slave modport (request in, results out)
module serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e          state_q;

  // Working copies of the accepted request. The operands shift right one
  // nibble per RUN cycle so the slice always reads bits [3:0].
  logic [W-1:0]    opA_q;
  logic [W-1:0]    opB_q;
  logic            op_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;

  // Partial result; finished nibbles enter at the top and move down, so
  // after the last nibble the value is in its final position.
  logic [W-1:0]    work_q;

  // Registered outputs
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            overflow_q;
  logic            zero_q;

  // Slice datapath
  logic [3:0]      aNib;
  logic [3:0]      bNib;
  logic [4:0]      sliceSum;
  logic            carry_d;
  logic            msbCarryIn;
  logic [W-1:0]    work_d;

  // The 4-bit add/subtract slice working on the current nibble. For
  // subtract B is inverted here and the +1 comes from the carry seeded at
  // accept. msbCarryIn recovers the carry into bit 3 of the slice from the
  // sum bit, which on the last nibble is the carry into bit W-1.
  always_comb begin
    aNib       = opA_q[3:0];
    bNib       = opB_q[3:0] ^ {4{op_q}};
    sliceSum   = {1'b0, aNib} + {1'b0, bNib} + {4'b0000, carry_q};
    carry_d    = sliceSum[4];
    msbCarryIn = sliceSum[3] ^ aNib[3] ^ bNib[3];
    work_d     = (work_q >> 4) | (W'(sliceSum[3:0]) << (W - 4));
  end

  // Sequencer: IDLE waits for start and captures the request; RUN pushes
  // one nibble through the slice per cycle and, on the last nibble, loads
  // the visible results and raises done on the same edge. The flags are
  // only loaded there, so they hold between operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      op_q       <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            opA_q   <= bus.a;
            opB_q   <= bus.b;
            op_q    <= bus.op;
            carry_q <= bus.op;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          opA_q   <= opA_q >> 4;
          opB_q   <= opB_q >> 4;
          work_q  <= work_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            result_q   <= work_d;
            cout_q     <= carry_d;
            overflow_q <= carry_d ^ msbCarryIn;
            zero_q     <= (work_d == '0);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule
